// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Brief    : Debounces eight key switches and assigns pressed keys to four
//            tone-generator voices. When all voices are busy, the least
//            recently allocated voice is stolen.
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int DEB_CYCLES = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    output logic [3:0]  voice_en,
    output logic [11:0] voice_note,
    output logic        steal,
    output logic [2:0]  active_cnt
);
    localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_deb_max = c_cnt_w'(DEB_CYCLES - 1);

    logic [7:0]         r_sync1, r_sync2, r_key_db, r_db_prev;
    logic [7:0]         r_press_pend, r_rel_pend;
    logic [c_cnt_w-1:0] r_deb_cnt [8];
    logic [3:0]         r_voice_en;
    logic [2:0]         r_note [4];
    logic [1:0]         r_rank [4];
    logic               r_steal;
    logic [2:0]         r_active_cnt;

    logic [7:0] w_rise, w_fall, w_clr_press, w_clr_rel, w_press_nxt, w_rel_nxt;
    logic [7:0] w_evt_vec;
    logic       w_do_rel, w_do_press, w_rel_hit, w_full, w_steal_nxt;
    logic [2:0] w_key, w_cnt_nxt;
    logic [1:0] w_rel_v, w_free_v, w_lru_v, w_alloc_v;
    logic [3:0] w_en_nxt;
    logic [2:0] w_note_nxt [4];
    logic [1:0] w_rank_nxt [4];

    // Two-flop synchronizer on the raw switches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key debounce: a key must disagree with its debounced state for
    // DEB_CYCLES consecutive cycles before that state flips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_db  <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < 8; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_db_prev <= r_key_db;
            for (int i = 0; i < 8; i++) begin
                if (r_sync2[i] == r_key_db[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == c_deb_max) begin
                    r_deb_cnt[i] <= '0;
                    r_key_db[i]  <= ~r_key_db[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_key_db & ~r_db_prev;
    assign w_fall = ~r_key_db & r_db_prev;

    // Pick the single event to service: releases first, lowest key first
    always_comb begin
        w_do_rel   = |r_rel_pend;
        w_do_press = ~w_do_rel & (|r_press_pend);
        w_evt_vec  = w_do_rel ? r_rel_pend : r_press_pend;
        w_key      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_evt_vec[i]) w_key = 3'(i);
        end
    end

    // Voice lookup: holder of the key, lowest free voice, and LRU victim
    always_comb begin
        w_rel_hit = 1'b0;
        w_rel_v   = 2'd0;
        w_free_v  = 2'd0;
        w_lru_v   = 2'd0;
        w_full    = &r_voice_en;
        for (int v = 3; v >= 0; v--) begin
            if (r_voice_en[v] && (r_note[v] == w_key)) begin
                w_rel_hit = 1'b1;
                w_rel_v   = 2'(v);
            end
            if (!r_voice_en[v])      w_free_v = 2'(v);
            if (r_rank[v] == 2'd0)   w_lru_v  = 2'(v);
        end
        w_alloc_v = w_full ? w_lru_v : w_free_v;
    end

    // Next voice state for the serviced event; ranks move only on allocation
    always_comb begin
        w_en_nxt    = r_voice_en;
        w_steal_nxt = 1'b0;
        w_clr_rel   = '0;
        w_clr_press = '0;
        for (int v = 0; v < 4; v++) begin
            w_note_nxt[v] = r_note[v];
            w_rank_nxt[v] = r_rank[v];
        end
        if (w_do_rel) begin
            w_clr_rel[w_key] = 1'b1;
            // A stolen key has no holder; its release is simply dropped
            if (w_rel_hit) w_en_nxt[w_rel_v] = 1'b0;
        end else if (w_do_press) begin
            w_clr_press[w_key]   = 1'b1;
            w_en_nxt[w_alloc_v]  = 1'b1;
            w_note_nxt[w_alloc_v] = w_key;
            w_steal_nxt          = w_full;
            for (int v = 0; v < 4; v++) begin
                if (r_rank[v] > r_rank[w_alloc_v]) w_rank_nxt[v] = r_rank[v] - 2'd1;
            end
            w_rank_nxt[w_alloc_v] = 2'd3;
        end
        w_cnt_nxt = 3'(w_en_nxt[0]) + 3'(w_en_nxt[1]) + 3'(w_en_nxt[2]) + 3'(w_en_nxt[3]);
    end

    // Pending-flag update: serviced flags clear, new edges set. A release that
    // lands on a still-pending press cancels that press; any older pending
    // release for the key is kept so its voice is still freed.
    always_comb begin
        w_press_nxt = r_press_pend & ~w_clr_press;
        w_rel_nxt   = r_rel_pend & ~w_clr_rel;
        for (int i = 0; i < 8; i++) begin
            if (w_rise[i]) w_press_nxt[i] = 1'b1;
            if (w_fall[i]) begin
                if (w_press_nxt[i]) w_press_nxt[i] = 1'b0;
                else                w_rel_nxt[i]   = 1'b1;
            end
        end
    end

    // Event flags and voice state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press_pend <= '0;
            r_rel_pend   <= '0;
            r_voice_en   <= '0;
            r_steal      <= 1'b0;
            r_active_cnt <= '0;
            for (int v = 0; v < 4; v++) begin
                r_note[v] <= '0;
                r_rank[v] <= 2'(v);
            end
        end else begin
            r_press_pend <= w_press_nxt;
            r_rel_pend   <= w_rel_nxt;
            r_voice_en   <= w_en_nxt;
            r_steal      <= w_steal_nxt;
            r_active_cnt <= w_cnt_nxt;
            for (int v = 0; v < 4; v++) begin
                r_note[v] <= w_note_nxt[v];
                r_rank[v] <= w_rank_nxt[v];
            end
        end
    end

    assign voice_en   = r_voice_en;
    assign voice_note = {r_note[3], r_note[2], r_note[1], r_note[0]};
    assign steal      = r_steal;
    assign active_cnt = r_active_cnt;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Scoreboard bench for voice_allocator with DEB_CYCLES = 4.
//            Stimulus queues expected output snapshots with their due cycle;
//            a monitor compares every observed output change against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic [3:0]  voice_en;
    logic [11:0] voice_note;
    logic        steal;
    logic [2:0]  active_cnt;

    typedef struct packed {
        logic [3:0]  en;
        logic [11:0] note;
        logic        st;
        logic [2:0]  cnt;
    } tup_t;

    typedef struct packed {
        int   due;
        tup_t t;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    tup_t prev  = '0;

    voice_allocator #(.DEB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .voice_en   (voice_en),
        .voice_note (voice_note),
        .steal      (steal),
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Observed outputs, with notes of idle voices masked out
    function automatic tup_t snap();
        tup_t s;
        s.en = voice_en;
        for (int v = 0; v < 4; v++)
            s.note[3*v +: 3] = voice_en[v] ? voice_note[3*v +: 3] : 3'd0;
        s.st  = steal;
        s.cnt = active_cnt;
        return s;
    endfunction

    // Expected snapshot; active count derived from the enable pattern
    function automatic tup_t mk(input logic [3:0] en, input int n0, input int n1,
                                input int n2, input int n3, input logic st);
        tup_t s;
        s.en   = en;
        s.note = {en[3] ? 3'(n3) : 3'd0, en[2] ? 3'(n2) : 3'd0,
                  en[1] ? 3'(n1) : 3'd0, en[0] ? 3'(n0) : 3'd0};
        s.st   = st;
        s.cnt  = 3'($countones(en));
        return s;
    endfunction

    task automatic push(input int due, input tup_t t);
        exp_t e;
        e.due = due;
        e.t   = t;
        exp_q.push_back(e);
    endtask

    task automatic set_sw(input logic [7:0] val, output int c);
        @(negedge clk);
        sw = val;
        c  = cyc;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (voice_en != 4'd0 || voice_note != 12'd0 || steal != 1'b0 || active_cnt != 3'd0) begin
            bad++;
            $display("FAIL %s: got en=%b note=%h steal=%b cnt=%0d, want all zero",
                     name, voice_en, voice_note, steal, active_cnt);
        end
    endtask

    // Monitor: every change of the observed outputs must match the next expectation
    initial begin
        tup_t cur;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cur = snap();
            if (cur != prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d: got en=%b note=%h st=%b cnt=%0d, want no change",
                             cyc, cur.en, cur.note, cur.st, cur.cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != cur || e.due != cyc) begin
                        bad++;
                        $display("FAIL scoreboard: got cyc=%0d en=%b note=%h st=%b cnt=%0d, want cyc=%0d en=%b note=%h st=%b cnt=%0d",
                                 cyc, cur.en, cur.note, cur.st, cur.cnt,
                                 e.due, e.t.en, e.t.note, e.t.st, e.t.cnt);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int c;
        rst = 1'b1;
        sw  = 8'h00;
        #1;
        check_zero("reset_state");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single press: sync 2 + debounce 4 + flag 1 + service 1
        set_sw(8'h01, c);
        push(c + 8, mk(4'b0001, 0, 0, 0, 0, 1'b0));
        repeat (12) @(negedge clk);
        set_sw(8'h00, c);
        push(c + 8, mk(4'b0000, 0, 0, 0, 0, 1'b0));
        repeat (12) @(negedge clk);

        // Three simultaneous presses serviced one per cycle in key order
        set_sw(8'h91, c);
        push(c + 8,  mk(4'b0001, 0, 0, 0, 0, 1'b0));
        push(c + 9,  mk(4'b0011, 0, 4, 0, 0, 1'b0));
        push(c + 10, mk(4'b0111, 0, 4, 7, 0, 1'b0));
        repeat (14) @(negedge clk);
        set_sw(8'h00, c);
        push(c + 8,  mk(4'b0110, 0, 4, 7, 0, 1'b0));
        push(c + 9,  mk(4'b0100, 0, 4, 7, 0, 1'b0));
        push(c + 10, mk(4'b0000, 0, 4, 7, 0, 1'b0));
        repeat (14) @(negedge clk);

        // Fill all voices in order, then steal the oldest
        set_sw(8'h01, c); push(c + 8, mk(4'b0001, 0, 0, 0, 0, 1'b0)); repeat (12) @(negedge clk);
        set_sw(8'h03, c); push(c + 8, mk(4'b0011, 0, 1, 0, 0, 1'b0)); repeat (12) @(negedge clk);
        set_sw(8'h07, c); push(c + 8, mk(4'b0111, 0, 1, 2, 0, 1'b0)); repeat (12) @(negedge clk);
        set_sw(8'h0F, c); push(c + 8, mk(4'b1111, 0, 1, 2, 3, 1'b0)); repeat (12) @(negedge clk);
        set_sw(8'h2F, c);
        push(c + 8, mk(4'b1111, 5, 1, 2, 3, 1'b1));
        push(c + 9, mk(4'b1111, 5, 1, 2, 3, 1'b0));
        repeat (12) @(negedge clk);
        // Release of the stolen key must not touch any voice
        set_sw(8'h2E, c);
        repeat (14) @(negedge clk);

        // Reset with a press pending, switches held through reset
        set_sw(8'h2F, c);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        push(cyc + 1, mk(4'b0000, 0, 0, 0, 0, 1'b0));
        #1;
        check_zero("reset_async");
        @(negedge clk);
        rst = 1'b0;
        c = cyc;
        push(c + 8,  mk(4'b0001, 0, 0, 0, 0, 1'b0));
        push(c + 9,  mk(4'b0011, 0, 1, 0, 0, 1'b0));
        push(c + 10, mk(4'b0111, 0, 1, 2, 0, 1'b0));
        push(c + 11, mk(4'b1111, 0, 1, 2, 3, 1'b0));
        push(c + 12, mk(4'b1111, 5, 1, 2, 3, 1'b1));
        push(c + 13, mk(4'b1111, 5, 1, 2, 3, 1'b0));
        repeat (16) @(negedge clk);

        // Clean restart with switches open
        sw  = 8'h00;
        rst = 1'b1;
        push(cyc + 1, mk(4'b0000, 0, 0, 0, 0, 1'b0));
        #1;
        check_zero("reset_clear");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Same-cycle release of key 1 and press of key 6
        set_sw(8'h03, c);
        push(c + 8, mk(4'b0001, 0, 0, 0, 0, 1'b0));
        push(c + 9, mk(4'b0011, 0, 1, 0, 0, 1'b0));
        repeat (12) @(negedge clk);
        set_sw(8'h41, c);
        push(c + 8, mk(4'b0001, 0, 1, 0, 0, 1'b0));
        push(c + 9, mk(4'b0011, 0, 6, 0, 0, 1'b0));
        repeat (12) @(negedge clk);

        // Bouncing key 2: toggles every 2 cycles for 20 cycles, then settles high
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            sw[2] = (k % 2 == 0);
            repeat (2) @(negedge clk);
        end
        sw[2] = 1'b1;
        c = cyc;
        push(c + 8, mk(4'b0111, 0, 6, 2, 0, 1'b0));

        // Static switches: nothing further may happen
        repeat (40) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_outputs: got %0d unmatched expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
